// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - op encodings as presented by the EX stage
//   - FSM state encoding
//   - iteration count and the divide-by-zero quotient
//   - small helpers to decode an op into divide / signed flags
package muldiv_pkg;

    localparam int          ITER_CNT  = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   is_div      : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_hi      : multiply partial product (upper) / divide partial remainder
//   acc_lo      : multiply multiplier bits (shifting out) / dividend bits
//                 shifting out with quotient bits shifting in
//   operand     : multiplicand / divisor magnitude (DATA_W+1 bits)
//   acc_hi_next, acc_lo_next : accumulator after this iteration
module muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic              is_div,
    input  logic [DATA_W-1:0] acc_hi,
    input  logic [DATA_W-1:0] acc_lo,
    input  logic [DATA_W:0]   operand,
    output logic [DATA_W-1:0] acc_hi_next,
    output logic [DATA_W-1:0] acc_lo_next
);

    logic [DATA_W:0]   add_sum;
    logic [DATA_W:0]   shifted;
    logic [DATA_W-1:0] diff;
    logic              fits;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift the whole {acc_hi, acc_lo} pair right by one.
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? operand : '0);

        // Divide: bring the next dividend bit into the partial remainder and
        // keep the trial difference only if it does not go negative. The
        // difference is taken modulo 2^DATA_W, which is exact whenever it fits
        // because the remainder is always smaller than the divisor.
        shifted = {acc_hi, acc_lo[DATA_W-1]};
        fits    = (shifted >= operand);
        diff    = shifted[DATA_W-1:0] - operand[DATA_W-1:0];

        if (is_div) begin
            acc_hi_next = fits ? diff : shifted[DATA_W-1:0];
            acc_lo_next = {acc_lo[DATA_W-2:0], fits};
        end else begin
            acc_hi_next = add_sum[DATA_W:1];
            acc_lo_next = {add_sum[0], acc_lo[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//   clk, rst        : clock, asynchronous active-high reset
//   cancel          : abort an operation in flight (only with MULDIV_CANCEL_EN)
//   start, op       : request strobe and opcode from EX, sampled in IDLE only
//   rs_val, rt_val  : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo      : write wr_data to HI / LO (honoured in IDLE only)
//   busy            : stall, high from the cycle after start until done
//   done            : one-cycle pulse in the cycle HI/LO show the new result
//   hi, lo          : HI and LO registers
// Optional feature macro: MULDIV_CANCEL_EN (adds the cancel input).
//
// Timing: the result is committed to HI/LO on the edge that leaves the last
// CALC cycle, so FIXUP is the cycle in which done is high and HI/LO already
// hold the signed result. Divide by zero skips straight from the first CALC
// cycle to FIXUP.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MULDIV_CANCEL_EN
    input  logic              cancel,
`endif
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int               CNT_W     = $clog2(ITER_CNT);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER_CNT - 1);

    state_e             state_reg;
    logic               is_div_reg;
    logic               neg_res_reg;   // operand signs differ
    logic               neg_rem_reg;   // signed dividend was negative
    logic               div0_reg;
    logic [CNT_W-1:0]   step_cnt_reg;
    logic [DATA_W-1:0]  acc_hi_reg;
    logic [DATA_W-1:0]  acc_lo_reg;
    logic [DATA_W:0]    operand_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [DATA_W-1:0]  hi_reg;
    logic [DATA_W-1:0]  lo_reg;

    // Input sign decode and magnitudes, one bit wider so |min_int| is exact.
    logic              rs_neg, rt_neg;
    logic [DATA_W:0]   rs_abs, rt_abs;
    logic              start_is_div;

    always_comb begin
        start_is_div = op_is_div(op);
        rs_neg = op_is_signed(op) & rs_val[DATA_W-1];
        rt_neg = op_is_signed(op) & rt_val[DATA_W-1];
        rs_abs = rs_neg ? -{rs_val[DATA_W-1], rs_val} : {1'b0, rs_val};
        rt_abs = rt_neg ? -{rt_val[DATA_W-1], rt_val} : {1'b0, rt_val};
    end

    logic [DATA_W-1:0] step_hi, step_lo;

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .is_div      (is_div_reg),
        .acc_hi      (acc_hi_reg),
        .acc_lo      (acc_lo_reg),
        .operand     (operand_reg),
        .acc_hi_next (step_hi),
        .acc_lo_next (step_lo)
    );

    // Sign fix-up of the final iteration's output.
    logic                last_step;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix, rem_fix, div0_hi;

    always_comb begin
        last_step = div0_reg || (step_cnt_reg == LAST_STEP);
        prod_fix  = neg_res_reg ? -{step_hi, step_lo} : {step_hi, step_lo};
        quot_fix  = neg_res_reg ? -step_lo : step_lo;
        rem_fix   = neg_rem_reg ? -step_hi : step_hi;
        // acc_lo still holds |rs| here; re-applying the sign restores rs_val.
        div0_hi   = neg_rem_reg ? -acc_lo_reg : acc_lo_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            is_div_reg   <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div0_reg     <= 1'b0;
            step_cnt_reg <= '0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            operand_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mthi) hi_reg <= wr_data;
                    if (mtlo) lo_reg <= wr_data;
                    if (start) begin
                        state_reg    <= CALC;
                        busy_reg     <= 1'b1;
                        is_div_reg   <= start_is_div;
                        neg_res_reg  <= rs_neg ^ rt_neg;
                        neg_rem_reg  <= rs_neg;
                        div0_reg     <= start_is_div && (rt_val == '0);
                        step_cnt_reg <= '0;
                        acc_hi_reg   <= '0;
                        // Multiply shifts the multiplier out of acc_lo; divide
                        // shifts the dividend out of it.
                        acc_lo_reg   <= start_is_div ? rs_abs[DATA_W-1:0] : rt_abs[DATA_W-1:0];
                        operand_reg  <= start_is_div ? rt_abs : rs_abs;
                    end
                end
                CALC: begin
                    acc_hi_reg   <= step_hi;
                    acc_lo_reg   <= step_lo;
                    step_cnt_reg <= step_cnt_reg + 1'b1;
                    if (last_step) begin
                        state_reg <= FIXUP;
                        done_reg  <= 1'b1;
                        if (div0_reg) begin
                            hi_reg <= div0_hi;
                            lo_reg <= DIV0_QUOT;
                        end else if (is_div_reg) begin
                            hi_reg <= rem_fix;
                            lo_reg <= quot_fix;
                        end else begin
                            hi_reg <= prod_fix[2*DATA_W-1:DATA_W];
                            lo_reg <= prod_fix[DATA_W-1:0];
                        end
                    end
                end
                FIXUP: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
`ifdef MULDIV_CANCEL_EN
            // Cancel overrides the case above: return to IDLE and keep HI/LO.
            // A cancel raised during FIXUP arrives after the commit edge, so
            // there it only ends the operation.
            if (cancel && (state_reg != IDLE)) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b0;
                hi_reg    <= hi_reg;
                lo_reg    <= lo_reg;
            end
`endif
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven bench for muldiv_unit.
// Cycle 0 is the cycle in which start is driven; inputs change and outputs are
// sampled on the falling edge.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val, wr_data;
    logic        mthi, mtlo;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MULDIV_CANCEL_EN
    logic        cancel;
`endif

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef MULDIV_CANCEL_EN
        .cancel  (cancel),
`endif
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    localparam int INJ_NONE   = 0;
    localparam int INJ_START  = 1;
    localparam int INJ_MTHI   = 2;
    localparam int INJ_RST    = 3;
    localparam int INJ_CANCEL = 4;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Issues one operation starting in the current cycle (caller is at a
    // falling edge) and watches up to 40 cycles. busy must be high exactly for
    // cycles 1..busy_last. Optionally injects an event in cycle inj_cyc, and
    // samples HI in the cycle after that.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int busy_last, input int inj_kind, input int inj_cyc,
                          output int n_done, output int done_cyc,
                          output logic [31:0] hi_d, output logic [31:0] lo_d,
                          output logic [31:0] hi_mid, output int busy_err);
        bit stop_early;
        stop_early = (inj_kind == INJ_NONE) || (inj_kind == INJ_START) || (inj_kind == INJ_MTHI);
        n_done = 0; done_cyc = -1; hi_d = '0; lo_d = '0; hi_mid = '0; busy_err = 0;
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rst = 1'b0;
`ifdef MULDIV_CANCEL_EN
            cancel = 1'b0;
`endif
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c; hi_d = hi; lo_d = lo;
                end
            end
            if (busy !== (c <= busy_last)) busy_err++;
            if (c == inj_cyc + 1) hi_mid = hi;
            if (c == inj_cyc) begin
                case (inj_kind)
                    INJ_START: begin
                        start = 1'b1; op = OP_DIVU; rs_val = 32'd55; rt_val = 32'd0;
                    end
                    INJ_MTHI: begin
                        mthi = 1'b1; wr_data = 32'hDEAD;
                    end
                    INJ_RST: rst = 1'b1;
`ifdef MULDIV_CANCEL_EN
                    INJ_CANCEL: cancel = 1'b1;
`endif
                    default: ;
                endcase
            end
            if (stop_early && (c == busy_last + 1)) break;
        end
    endtask

    int          nd, dc, be;
    logic [31:0] hd, ld, hm;

    initial begin
        vecs[0]  = '{OP_MULT,  32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{OP_DIV,   32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[4]  = '{OP_DIVU,  32'd100,        32'd0,        32'd100,      32'hFFFFFFFF, 2};
        vecs[5]  = '{OP_DIVU,  32'd100,        32'd7,        32'd2,        32'd14,       33};
        vecs[6]  = '{OP_DIV,   32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        vecs[7]  = '{OP_DIV,   32'hFFFFFFF8,   32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        33};
        vecs[8]  = '{OP_MULT,  32'h80000000,   32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[9]  = '{OP_DIV,   32'hFFFFFF9C,   32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 2};
        vecs[10] = '{OP_MULTU, 32'h00010000,   32'h00010000, 32'd1,        32'd0,        33};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFFF,   32'd1,        32'd0,        32'hFFFFFFFF, 33};
        vecs[12] = '{OP_MULT,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'd0,        32'd1,        33};

        rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; rs_val = '0; rt_val = '0; wr_data = '0;
`ifdef MULDIV_CANCEL_EN
        cancel = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", busy, 1'b0);

        // MTHI / MTLO in IDLE
        wr_data = 32'h1234; mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi hi", hi, 32'h1234);
        check("mthi lo", lo, 32'd0);
        wr_data = 32'h5678; mtlo = 1'b1;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo lo", lo, 32'h5678);
        check("mtlo hi", hi, 32'h1234);
        $display("mt: hi=0x%08h lo=0x%08h", hi, lo);

        // Table of operations, issued back to back
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].cyc, INJ_NONE, 0,
                   nd, dc, hd, ld, hm, be);
            $display("vec %0d: op=%0d rs=0x%08h rt=0x%08h -> done@%0d hi=0x%08h lo=0x%08h",
                     i, vecs[i].op, vecs[i].rs, vecs[i].rt, dc, hd, ld);
            check($sformatf("v%0d done_cycle", i), 64'(dc), 64'(vecs[i].cyc));
            check($sformatf("v%0d done_count", i), 64'(nd), 64'd1);
            check($sformatf("v%0d hi", i), hd, vecs[i].hi);
            check($sformatf("v%0d lo", i), ld, vecs[i].lo);
            check($sformatf("v%0d busy_errors", i), 64'(be), 64'd0);
        end

        // Second start while busy is ignored
        run_op(OP_MULTU, 32'd6, 32'd7, 33, INJ_START, 5, nd, dc, hd, ld, hm, be);
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
            if (busy !== 1'b0) be++;
        end
        $display("restart: done@%0d count=%0d hi=0x%08h lo=0x%08h", dc, nd, hd, ld);
        check("restart done_count", 64'(nd), 64'd1);
        check("restart done_cycle", 64'(dc), 64'd33);
        check("restart lo", ld, 32'd42);
        check("restart busy_errors", 64'(be), 64'd0);

        // MTHI while busy is ignored
        run_op(OP_MULTU, 32'd2, 32'd3, 33, INJ_MTHI, 3, nd, dc, hd, ld, hm, be);
        $display("mthi busy: hi_mid=0x%08h hi=0x%08h lo=0x%08h", hm, hd, ld);
        check("mthi_busy hi_mid", hm, 32'd0);
        check("mthi_busy hi", hd, 32'd0);
        check("mthi_busy lo", ld, 32'd6);

        // MTHI in the same cycle as start: write lands, result overwrites it
        wr_data = 32'hABCD; mthi = 1'b1;
        run_op(OP_MULTU, 32'h00010000, 32'h00010000, 33, INJ_NONE, 1, nd, dc, hd, ld, hm, be);
        $display("mthi+start: hi_mid=0x%08h hi=0x%08h lo=0x%08h", hm, hd, ld);
        check("mt_start hi_mid", hm, 32'hABCD);
        check("mt_start hi", hd, 32'd1);
        check("mt_start done_cycle", 64'(dc), 64'd33);

        // Reset in the middle of an operation
        wr_data = 32'h1234; mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        run_op(OP_MULTU, 32'd3, 32'd5, 10, INJ_RST, 10, nd, dc, hd, ld, hm, be);
        $display("reset mid-op: done count=%0d hi=0x%08h lo=0x%08h", nd, hi, lo);
        check("midrst done_count", 64'(nd), 64'd0);
        check("midrst busy_errors", 64'(be), 64'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);

`ifdef MULDIV_CANCEL_EN
        // Cancel in CALC keeps the pre-start HI/LO
        wr_data = 32'h1234; mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0; wr_data = 32'h77; mtlo = 1'b1;
        @(negedge clk);
        mtlo = 1'b0;
        run_op(OP_MULT, 32'd9, 32'd9, 10, INJ_CANCEL, 10, nd, dc, hd, ld, hm, be);
        $display("cancel: done count=%0d hi=0x%08h lo=0x%08h", nd, hi, lo);
        check("cancel done_count", 64'(nd), 64'd0);
        check("cancel busy_errors", 64'(be), 64'd0);
        check("cancel hi", hi, 32'h1234);
        check("cancel lo", lo, 32'h77);
        run_op(OP_DIVU, 32'd100, 32'd7, 33, INJ_NONE, 0, nd, dc, hd, ld, hm, be);
        $display("after cancel: done@%0d hi=0x%08h lo=0x%08h", dc, hd, ld);
        check("post_cancel hi", hd, 32'd2);
        check("post_cancel lo", ld, 32'd14);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
